div_seq16: RTL and testbench

Sequential 16-bit unsigned restoring divider for the processor's multdiv unit. It is the direct consumer of the 4-bit `counter_16` iteration counter: it drives the counter's `en`/`clr` and uses its `q` to terminate after 16 iterations. Operands arrive with a one-cycle `start` strobe. Quotient and remainder return with a one-cycle `ready` pulse and a divide-by-zero flag. It sits between the ALU operand latches and the writeback mux.

---
 rtl/div_pkg.sv | 27 ++
 rtl/counter_16.sv | 40 ++++
 rtl/div_seq16.sv | 151 +++++++++++++++
 tb/tb_div_seq16.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the div_seq16 sequential
//                restoring divider and its iteration counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  // Divider control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // One quotient bit per iteration; also the operand width
  localparam int          DIV_ITERS     = 16;
  // Counter value on the final iteration
  localparam logic [3:0]  DIV_LAST_ITER = 4'd15;
  // Quotient reported for a zero divisor
  localparam logic [15:0] DIV0_QUOTIENT = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/counter_16.sv
// ============================================================================
//  Module      : counter_16
//  Description : 4-bit iteration counter (counts 0..15, wraps to 0).
//                clr is a synchronous clear with priority over en.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                clr   - synchronous clear
//                en    - count enable
//                q     - current count
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_16
  import div_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else if (clr) begin
      cnt_q <= 4'd0;
    end else if (en) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign q = cnt_q;

endmodule

`default_nettype wire

// File: rtl/div_seq16.sv
// ============================================================================
//  Module      : div_seq16
//  Description : Sequential 16-bit unsigned restoring divider. One quotient
//                bit per cycle; 17 cycles from start to ready, 1 cycle for a
//                zero divisor.
//  Ports       : clk       - clock, rising edge
//                clr       - asynchronous active-low reset
//                start     - request strobe, sampled in IDLE only
//                dividend  - 16-bit unsigned dividend (sampled with start)
//                divisor   - 16-bit unsigned divisor  (sampled with start)
//                quotient  - registered quotient
//                remainder - registered remainder
//                busy      - high in RUN and DONE
//                ready     - one-cycle result-valid pulse
//                div0      - divisor was zero; held with the result
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq16
  import div_pkg::*;
(
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [DIV_ITERS-1:0] dividend,
  input  logic [DIV_ITERS-1:0] divisor,
  output logic [DIV_ITERS-1:0] quotient,
  output logic [DIV_ITERS-1:0] remainder,
  output logic                 busy,
  output logic                 ready,
  output logic                 div0
);

  div_state_e           state_q, state_d;
  logic [DIV_ITERS-1:0] wq_q, wq_d;       // working quotient / dividend shifter
  // Partial remainder. The 17-bit trial lives in s/d; the kept value is
  // always below the divisor, so its MSB is 0 and only 16 bits are stored.
  logic [DIV_ITERS-1:0] rem_q, rem_d;
  logic [DIV_ITERS-1:0] dvs_q, dvs_d;     // captured divisor
  logic [DIV_ITERS-1:0] quot_q, quot_d;
  logic [DIV_ITERS-1:0] remo_q, remo_d;
  logic                 div0_q, div0_d;
  logic                 load;

  logic [DIV_ITERS:0]   s;
  logic [DIV_ITERS:0]   d;
  logic [3:0]           cnt;

  assign s = {rem_q, wq_q[DIV_ITERS-1]};
  assign d = s - {1'b0, dvs_q};

  // Clearing on reset as well as on load keeps the count aligned to E1.
  counter_16 u_iter_cnt (
    .clk   (clk),
    .rst_n (clr),
    .clr   (~clr | load),
    .en    (state_q == RUN),
    .q     (cnt)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wq_q   <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      quot_q <= '0;
      remo_q <= '0;
      div0_q <= 1'b0;
    end else begin
      wq_q   <= wq_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quot_q <= quot_d;
      remo_q <= remo_d;
      div0_q <= div0_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wq_d    = wq_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    div0_d  = div0_q;
    load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            load    = 1'b1;
            wq_d    = dividend;
            rem_d   = '0;
            dvs_d   = divisor;
            state_d = RUN;
          end else begin
            quot_d  = DIV0_QUOTIENT;
            remo_d  = dividend;
            div0_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      RUN: begin
        // Negative trial (borrow) means restore: keep the shifted value.
        if (!d[DIV_ITERS]) begin
          rem_d = d[DIV_ITERS-1:0];
          wq_d  = {wq_q[DIV_ITERS-2:0], 1'b1};
        end else begin
          rem_d = s[DIV_ITERS-1:0];
          wq_d  = {wq_q[DIV_ITERS-2:0], 1'b0};
        end
        if (cnt == DIV_LAST_ITER) begin
          quot_d  = wq_d;
          remo_d  = rem_d;
          div0_d  = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign div0      = div0_q;
  assign busy      = (state_q != IDLE);
  assign ready     = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_div_seq16.sv
// ============================================================================
//  Module      : tb_div_seq16
//  Description : Self-checking bench for div_seq16 with a behavioural
//                reference model (integer divide / modulo).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_seq16;

  logic        clk;
  logic        clr;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        ready;
  logic        div0;

  int n_vec;
  int n_err;

  div_seq16 dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .ready     (ready),
    .div0      (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [15:0] b);
    return (b == 16'd0) ? 16'hFFFF : 16'(a / b);
  endfunction
  function automatic logic [15:0] ref_r(input logic [15:0] a, input logic [15:0] b);
    return (b == 16'd0) ? a : 16'(a % b);
  endfunction

  // Issue one request and wait for ready; lat = cycle index of ready after
  // the start cycle (0 = timed out). Returns at the negedge of the ready cycle.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, output int lat);
    @(posedge clk); #1;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ready) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    clr = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({quotient, remainder, busy, ready, div0} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_hold: got q=%h r=%h busy=%b ready=%b div0=%b, need all 0",
               quotient, remainder, busy, ready, div0);
    end
    clr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if ({quotient, remainder, busy, ready, div0} !== 35'd0) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: got q=%h r=%h busy=%b ready=%b div0=%b, need all 0",
                 i, quotient, remainder, busy, ready, div0);
      end
    end
  endtask

  task automatic test_basic;
    int lat;
    do_op(16'd100, 16'd7, lat);
    n_vec++;
    if (lat !== 17 || quotient !== 16'd14 || remainder !== 16'd2 || div0 !== 1'b0) begin
      n_err++;
      $display("FAIL basic_100_7: got lat=%0d q=%0d r=%0d div0=%b, need lat=17 q=14 r=2 div0=0",
               lat, quotient, remainder, div0);
    end
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_after_ready: got ready=%b busy=%b, need 0 0", ready, busy);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (quotient !== 16'd14 || remainder !== 16'd2) begin
      n_err++;
      $display("FAIL basic_hold: got q=%0d r=%0d, need 14 2", quotient, remainder);
    end
  endtask

  task automatic test_boundary;
    logic [15:0] ta [4];
    logic [15:0] tb [4];
    logic [15:0] tq [4];
    logic [15:0] tr [4];
    int lat;
    ta = '{16'hFFFF, 16'd5,  16'hFFFF, 16'd0};
    tb = '{16'd1,    16'd10, 16'hFFFF, 16'd3};
    tq = '{16'hFFFF, 16'd0,  16'd1,    16'd0};
    tr = '{16'd0,    16'd5,  16'd0,    16'd0};
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], lat);
      n_vec++;
      if (lat !== 17 || quotient !== tq[i] || remainder !== tr[i] || div0 !== 1'b0) begin
        n_err++;
        $display("FAIL boundary %h/%h: got lat=%0d q=%h r=%h div0=%b, need lat=17 q=%h r=%h div0=0",
                 ta[i], tb[i], lat, quotient, remainder, div0, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_div0;
    int lat;
    do_op(16'd1234, 16'd0, lat);
    n_vec++;
    if (lat !== 1 || quotient !== 16'hFFFF || remainder !== 16'd1234 || div0 !== 1'b1) begin
      n_err++;
      $display("FAIL div0_1234: got lat=%0d q=%h r=%0d div0=%b, need lat=1 q=ffff r=1234 div0=1",
               lat, quotient, remainder, div0);
    end
  endtask

  // 100/7 with ignored starts at cycles 5 and 16, then 9/2 the cycle after ready
  task automatic test_back_to_back;
    int rdy_cnt;
    int rdy_at [2];
    logic [15:0] rq [2];
    logic [15:0] rr [2];
    rdy_cnt = 0;
    rdy_at = '{0, 0};
    rq = '{16'd0, 16'd0};
    rr = '{16'd0, 16'd0};
    @(posedge clk); #1;
    start = 1'b1; dividend = 16'd100; divisor = 16'd7;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 5 || n == 16 || n == 18) begin
        start = 1'b1; dividend = 16'd9; divisor = 16'd2;
      end else begin
        start = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
      end
      @(negedge clk);
      if (n == 1) begin
        n_vec++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_busy_rise: got busy=%b, need 1", busy);
        end
      end
      if (ready) begin
        if (rdy_cnt < 2) begin
          rdy_at[rdy_cnt] = n;
          rq[rdy_cnt] = quotient;
          rr[rdy_cnt] = remainder;
        end
        rdy_cnt++;
      end
    end
    start = 1'b0;
    n_vec++;
    if (rdy_cnt !== 2) begin
      n_err++;
      $display("FAIL b2b_ready_count: got %0d ready pulses, need 2", rdy_cnt);
    end
    n_vec++;
    if (rdy_at[0] !== 17 || rq[0] !== 16'd14 || rr[0] !== 16'd2) begin
      n_err++;
      $display("FAIL b2b_first: got cycle=%0d q=%0d r=%0d, need cycle=17 q=14 r=2",
               rdy_at[0], rq[0], rr[0]);
    end
    n_vec++;
    if (rdy_at[1] !== 35 || rq[1] !== 16'd4 || rr[1] !== 16'd1) begin
      n_err++;
      $display("FAIL b2b_second: got cycle=%0d q=%0d r=%0d, need cycle=35 q=4 r=1",
               rdy_at[1], rq[1], rr[1]);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen;
    seen = 0;
    @(posedge clk); #1;
    start = 1'b1; dividend = 16'd100; divisor = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    clr = 1'b0;
    #1;
    n_vec++;
    if ({quotient, remainder, busy, ready, div0} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_mid_async: got q=%h r=%h busy=%b ready=%b div0=%b, need all 0",
               quotient, remainder, busy, ready, div0);
    end
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready || busy) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL reset_mid_discard: got %0d cycles with ready/busy, need 0", seen);
    end
    do_op(16'd100, 16'd7, lat);
    n_vec++;
    if (lat !== 17 || quotient !== 16'd14 || remainder !== 16'd2 || div0 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_fresh: got lat=%0d q=%0d r=%0d div0=%b, need lat=17 q=14 r=2 div0=0",
               lat, quotient, remainder, div0);
    end
  endtask

  task automatic test_random;
    logic [15:0] a;
    logic [15:0] b;
    int lat;
    int exp_lat;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      exp_lat = (b == 16'd0) ? 1 : 17;
      do_op(a, b, lat);
      n_vec++;
      if (lat !== exp_lat || quotient !== ref_q(a, b) || remainder !== ref_r(a, b) ||
          div0 !== (b == 16'd0)) begin
        n_err++;
        $display("FAIL random %h/%h: got lat=%0d q=%h r=%h div0=%b, need lat=%0d q=%h r=%h div0=%b",
                 a, b, lat, quotient, remainder, div0, exp_lat, ref_q(a, b), ref_r(a, b),
                 (b == 16'd0));
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_boundary();
    test_div0();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
